// File: rtl/layer_stream_sequencer.sv
// rtl/layer_stream_sequencer.sv - double-buffered vector capture streamed element by element into a neuron layer
module layer_stream_sequencer #(
  parameter int NUM_IN     = 30,
  parameter int DATA_WIDTH = 16,
  parameter int GAP_CYCLES = 1,
  parameter int TIMEOUT    = 64
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_IN*DATA_WIDTH-1:0] in_data,
  input  logic                         in_valid,
  output logic                         in_ready,
  output logic [DATA_WIDTH-1:0]        x_data,
  output logic                         x_valid,
  input  logic                         nrn_outvalid,
  output logic                         layer_done,
  output logic                         busy,
  output logic                         timeout_err,
  input  logic                         err_clr
);
  localparam int IW = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;
  localparam int WW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int GW = $clog2(GAP_CYCLES + 1);
  localparam logic [IW-1:0] LAST_IDX  = IW'(NUM_IN - 1);
  localparam logic [WW-1:0] WAIT_LAST = WW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, STREAM, WAIT, GAP} state_t;

  state_t                state;
  logic [DATA_WIDTH-1:0] elem [2][NUM_IN];
  logic [1:0]            full;
  logic                  wr_bank;
  logic                  rd_bank;
  logic [IW-1:0]         idx;
  logic [IW-1:0]         idx_next;
  logic [WW-1:0]         wcnt;
  logic [GW-1:0]         gcnt;
  logic                  capture;
  logic                  release_bank;

  assign in_ready     = !full[wr_bank];
  assign capture      = in_valid && in_ready;
  assign release_bank = (state == STREAM) && (idx == LAST_IDX);
  assign busy         = (state != IDLE) || (|full);
  assign idx_next     = idx + 1'b1;

  // Bank contents need no reset: full[] alone decides whether a bank is meaningful.
  always_ff @(posedge clk) begin
    if (capture) begin
      for (int i = 0; i < NUM_IN; i++) begin
        elem[wr_bank][i] <= in_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      full        <= '0;
      wr_bank     <= 1'b0;
      rd_bank     <= 1'b0;
      idx         <= '0;
      wcnt        <= '0;
      gcnt        <= '0;
      x_valid     <= 1'b0;
      x_data      <= '0;
      layer_done  <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      layer_done <= 1'b0;
      if (err_clr) timeout_err <= 1'b0;
      // Capture and release always target different banks, so both may happen at once.
      if (capture) begin
        full[wr_bank] <= 1'b1;
        wr_bank       <= !wr_bank;
      end
      if (release_bank) full[rd_bank] <= 1'b0;

      case (state)
        IDLE: begin
          if (full[rd_bank]) begin
            state   <= STREAM;
            x_valid <= 1'b1;
            x_data  <= elem[rd_bank][0];
            idx     <= '0;
          end
        end
        STREAM: begin
          if (idx == LAST_IDX) begin
            rd_bank <= !rd_bank;
            idx     <= '0;
            x_valid <= 1'b0;
            wcnt    <= '0;
            state   <= WAIT;
          end else begin
            idx    <= idx_next;
            x_data <= elem[rd_bank][idx_next];
          end
        end
        WAIT: begin
          if (nrn_outvalid) begin
            layer_done <= 1'b1;
            gcnt       <= '0;
            state      <= GAP;
          end else if ((TIMEOUT != 0) && (wcnt == WAIT_LAST)) begin
            timeout_err <= 1'b1;
            gcnt        <= '0;
            state       <= GAP;
          end else begin
            wcnt <= wcnt + 1'b1;
          end
        end
        GAP: begin
          if (gcnt == GAP_LAST) state <= IDLE;
          else gcnt <= gcnt + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_layer_stream_sequencer.sv
// tb/tb_layer_stream_sequencer.sv - self-checking bench for layer_stream_sequencer
module tb_layer_stream_sequencer;
  localparam int NUM_IN = 30;
  localparam int DW     = 16;
  localparam int GAP    = 1;
  localparam int TMO    = 64;
  localparam int VW     = NUM_IN * DW;

  logic          clk;
  logic          rst;
  logic [VW-1:0] in_data;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] x_data;
  logic          x_valid;
  logic          nrn_outvalid;
  logic          layer_done;
  logic          busy;
  logic          timeout_err;
  logic          err_clr;

  layer_stream_sequencer #(
    .NUM_IN(NUM_IN), .DATA_WIDTH(DW), .GAP_CYCLES(GAP), .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .x_data(x_data), .x_valid(x_valid), .nrn_outvalid(nrn_outvalid), .layer_done(layer_done),
    .busy(busy), .timeout_err(timeout_err), .err_clr(err_clr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Transaction-level reference: accepted vectors in order, with the earliest cycle each may stream.
  typedef struct {
    logic [VW-1:0] data;
    int            avail;
  } vec_t;
  vec_t          acc_q[$];
  logic [VW-1:0] cur;
  logic          prev_xv;
  int            blen, bmis, occ, wc, gap_end, ready_cycle;
  logic          waiting, exp_done, m_err, new_err;

  always @(negedge clk) begin
    if (rst) begin
      acc_q.delete();
      prev_xv = 1'b0; blen = 0; bmis = 0; occ = 0; wc = 0;
      gap_end = -1; ready_cycle = 0;
      waiting = 1'b0; exp_done = 1'b0; m_err = 1'b0;
    end else begin
      if (x_valid && !prev_xv) begin
        check("start_has_vec", acc_q.size() > 0, 1);
        if (acc_q.size() > 0) begin
          cur = acc_q[0].data;
          check("start_cycle", cyc, (ready_cycle > acc_q[0].avail) ? ready_cycle : acc_q[0].avail);
        end
        blen = 0; bmis = 0; ready_cycle = 32'h7fffffff;
      end
      if (x_valid) begin
        if (blen < NUM_IN && x_data != cur[blen*DW +: DW]) bmis++;
        blen++;
      end
      if (!x_valid && prev_xv) begin
        check("burst_len", blen, NUM_IN);
        check("burst_data", bmis, 0);
        if (acc_q.size() > 0) void'(acc_q.pop_front());
        occ--;
        waiting = 1'b1;
        wc = 0;
      end
      check("layer_done", layer_done, exp_done);
      check("timeout_err", timeout_err, m_err);
      check("in_ready", in_ready, occ < 2);
      check("busy", busy, (occ > 0) || waiting || (cyc <= gap_end));
      exp_done = 1'b0;
      new_err  = 1'b0;
      if (waiting) begin
        if (nrn_outvalid) begin
          exp_done = 1'b1; waiting = 1'b0;
        end else if (TMO != 0 && wc == TMO - 1) begin
          new_err = 1'b1; waiting = 1'b0;
        end else begin
          wc++;
        end
        if (!waiting) begin
          gap_end     = cyc + GAP;
          ready_cycle = cyc + GAP + 2;
        end
      end
      m_err = new_err ? 1'b1 : (err_clr ? 1'b0 : m_err);
      if (in_valid && in_ready) begin
        acc_q.push_back('{data: in_data, avail: cyc + 2});
        occ++;
      end
      prev_xv = x_valid;
    end
  end

  task automatic offer(input logic [VW-1:0] v);
    int n = 0;
    in_data  = v;
    in_valid = 1'b1;
    while (!in_ready && n < 300) begin tick(); n++; end
    check("offer_bound", n < 300, 1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_xv(input logic lvl, input string name);
    int n = 0;
    while (x_valid !== lvl && n < 500) begin tick(); n++; end
    check(name, n < 500, 1);
  endtask

  function automatic logic [VW-1:0] rand_vec();
    logic [VW-1:0] v;
    for (int i = 0; i < NUM_IN; i++) v[i*DW +: DW] = DW'($urandom);
    return v;
  endfunction

  typedef struct {
    int lat;
    bit exp_done;
    bit exp_err;
    int exp_off;
  } row_t;
  row_t tbl[6];

  initial begin
    logic [VW-1:0] v;
    int cnt, mis, t_w, done_off, err_off, done_w;
    bit hold_bad;

    tbl[0] = '{lat: 1,  exp_done: 1'b1, exp_err: 1'b0, exp_off: 2};
    tbl[1] = '{lat: 5,  exp_done: 1'b1, exp_err: 1'b0, exp_off: 6};
    tbl[2] = '{lat: 64, exp_done: 1'b1, exp_err: 1'b0, exp_off: 65};
    tbl[3] = '{lat: 65, exp_done: 1'b0, exp_err: 1'b1, exp_off: 65};
    tbl[4] = '{lat: 0,  exp_done: 1'b0, exp_err: 1'b1, exp_off: 65};
    tbl[5] = '{lat: 30, exp_done: 1'b1, exp_err: 1'b0, exp_off: 31};

    rst = 1'b1; in_valid = 1'b0; in_data = '0; nrn_outvalid = 1'b0; err_clr = 1'b0;
    repeat (3) tick();
    check("rst_x_valid", x_valid, 0);
    check("rst_x_data", x_data, 0);
    check("rst_layer_done", layer_done, 0);
    check("rst_timeout_err", timeout_err, 0);
    check("rst_busy", busy, 0);
    rst = 1'b0;
    tick();
    check("rst_in_ready", in_ready, 1);

    // Single vector with element i = i+1.
    for (int i = 0; i < NUM_IN; i++) v[i*DW +: DW] = DW'(i + 1);
    offer(v);
    wait_xv(1'b1, "t1_start");
    cnt = 0; mis = 0;
    while (x_valid && cnt < 40) begin
      if (x_data != DW'(cnt + 1)) mis++;
      cnt++;
      tick();
    end
    check("t1_len", cnt, NUM_IN);
    check("t1_data", mis, 0);
    nrn_outvalid = 1'b1;
    tick();
    nrn_outvalid = 1'b0;
    check("t1_done", layer_done, 1);
    repeat (3) tick();

    // A then B while A streams; third offer must stall; B waits for A's completion plus gap.
    offer(rand_vec());
    wait_xv(1'b1, "t2_a_start");
    check("t2_ready_b", in_ready, 1);
    offer(rand_vec());
    in_data = rand_vec();
    in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      check("t2_ready_c", in_ready, 0);
      tick();
    end
    in_valid = 1'b0;
    wait_xv(1'b0, "t2_a_end");
    hold_bad = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (x_valid) hold_bad = 1'b1;
      tick();
    end
    check("t2_hold_b", hold_bad, 0);
    t_w = cyc;
    nrn_outvalid = 1'b1;
    tick();
    nrn_outvalid = 1'b0;
    wait_xv(1'b1, "t2_b_start");
    check("t2_spacing", cyc - t_w, GAP + 2);
    wait_xv(1'b0, "t2_b_end");
    nrn_outvalid = 1'b1;
    tick();
    nrn_outvalid = 1'b0;
    repeat (4) tick();

    // Completion latency, timeout boundary and late outvalid, one vector per row.
    for (int r = 0; r < 6; r++) begin
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      check("tbl_err_clr", timeout_err, 0);
      offer(rand_vec());
      wait_xv(1'b1, "tbl_start");
      wait_xv(1'b0, "tbl_end");
      done_off = -1; err_off = -1; done_w = 0;
      for (int k = 1; k <= 70; k++) begin
        nrn_outvalid = (tbl[r].lat == k);
        if (layer_done) begin
          done_w++;
          if (done_off < 0) done_off = k;
        end
        if (timeout_err && err_off < 0) err_off = k;
        tick();
      end
      nrn_outvalid = 1'b0;
      check("tbl_done", done_off >= 0, tbl[r].exp_done);
      check("tbl_err", err_off >= 0, tbl[r].exp_err);
      check("tbl_offset", tbl[r].exp_done ? done_off : err_off, tbl[r].exp_off);
      if (tbl[r].exp_done) check("tbl_done_width", done_w, 1);
      check("tbl_idle", busy, 0);
    end

    // Spurious outvalid while idle.
    nrn_outvalid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      check("spur_done", layer_done, 0);
      tick();
    end
    nrn_outvalid = 1'b0;

    // Random traffic against the reference model.
    for (int k = 0; k < 3000; k++) begin
      in_valid     = ($urandom_range(0, 2) == 0);
      in_data      = rand_vec();
      nrn_outvalid = ($urandom_range(0, 11) == 0);
      err_clr      = ($urandom_range(0, 49) == 0);
      tick();
    end
    in_valid = 1'b0; err_clr = 1'b0; nrn_outvalid = 1'b1;
    repeat (120) tick();
    nrn_outvalid = 1'b0;
    check("drain_idle", busy, 0);

    // Reset in the middle of a stream.
    for (int i = 0; i < NUM_IN; i++) v[i*DW +: DW] = DW'(100 + i);
    offer(v);
    wait_xv(1'b1, "t5_start");
    repeat (12) tick();
    check("t5_elem12", x_data, 112);
    rst = 1'b1;
    #1;
    check("t5_xv_drop", x_valid, 0);
    tick();
    rst = 1'b0;
    tick();
    check("t5_in_ready", in_ready, 1);
    check("t5_busy", busy, 0);
    check("t5_xv", x_valid, 0);
    repeat (5) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
